// File: rtl/tinynpu_dma_pkg.sv
// Shared types and constants for the register-file <-> SDRAM DMA.
//   dma_dir_t   : command direction (load = SDRAM->RF, store = RF->SDRAM)
//   dma_state_t : sequencer states shared by the load and store paths
//   SDRAM_AW    : SDRAM word-address width
package tinynpu_dma_pkg;

  typedef enum logic {
    DMA_LOAD  = 1'b0,
    DMA_STORE = 1'b1
  } dma_dir_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    S_RD   = 3'd1,
    S_CAP  = 3'd2,
    S_WR   = 3'd3,
    L_RUN  = 3'd4,
    S_DONE = 3'd5
  } dma_state_t;

  localparam int unsigned SDRAM_AW = 25;

endpackage

// File: rtl/dma_row_serdes.sv
// Row shift register shared by both DMA directions.
//   clk, rst_n  : clock, synchronous active-low reset
//   clear       : restart the beat counter (new command)
//   load        : parallel-load load_data (store path), beat counter to 0
//   shift_out   : drop the low word, advance beat (store path)
//   shift_in    : shift beat_data in at the top, advance beat (load path)
//   beat_data   : incoming SDRAM beat
//   tx_word     : low word of the register, i.e. the next beat to write
//   rx_row      : register contents with beat_data already shifted in
//   last_beat   : current beat is the final beat of the row
module dma_row_serdes #(
  parameter int unsigned N  = 256,
  parameter int unsigned DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          load,
  input  logic [N-1:0]  load_data,
  input  logic          shift_out,
  input  logic          shift_in,
  input  logic [DW-1:0] beat_data,
  output logic [DW-1:0] tx_word,
  output logic [N-1:0]  rx_row,
  output logic          last_beat
);

  localparam int unsigned BEATS = N / DW;
  localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [N-1:0]  sr;
  logic [BW-1:0] beat;

  // LSW leaves first; returning beats enter at the top so beat 0 ends up in the LSW.
  assign tx_word   = sr[DW-1:0];
  assign rx_row    = (N'(beat_data) << (N - DW)) | (sr >> DW);
  assign last_beat = (beat == BW'(BEATS - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr   <= '0;
      beat <= '0;
    end else if (clear) begin
      beat <= '0;
    end else if (load) begin
      sr   <= load_data;
      beat <= '0;
    end else if (shift_out || shift_in) begin
      sr   <= shift_in ? rx_row : (sr >> DW);
      beat <= last_beat ? '0 : beat + BW'(1);
    end
  end

endmodule

// File: rtl/rf_sdram_dma.sv
// Row-granular DMA between the NPU register file and off-chip SDRAM.
// Store (RF->SDRAM) reads one RF row, then writes it as N/SDRAM_DW beats, LSW first.
// Load (SDRAM->RF) pipelines up to MAX_OUTSTANDING read beats and writes each
// assembled row into the RF the cycle after its last beat returns.
// Ports:
//   clk, rst_n                         clock, synchronous active-low reset
//   cmd_valid/cmd_ready                command handshake (ready only when idle)
//   cmd_dir/cmd_rf_addr/cmd_sdram_addr/cmd_len  command fields
//   done, err                          one-cycle retire / reject pulses
//   rf_rd_en/rf_rd_addr/rf_rd_data     RF read port (1-cycle latency)
//   rf_wr_en/rf_wr_addr/rf_wr_data     RF write port
//   sdram_*                            Avalon-MM-style master
// Optional feature: define RF_DMA_BOUNDS_CHECK_EN to reject commands that would
// run past the top of RF or SDRAM address space (err pulse, no bus activity).
// Without it err stays 0 and addresses wrap.
module rf_sdram_dma
  import tinynpu_dma_pkg::*;
#(
  parameter int unsigned ADDR_W          = 9,
  parameter int unsigned N               = 256,
  parameter int unsigned SDRAM_DW        = 16,
  parameter int unsigned LEN_W           = 9,
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_dir,
  input  logic [ADDR_W-1:0]   cmd_rf_addr,
  input  logic [SDRAM_AW-1:0] cmd_sdram_addr,
  input  logic [LEN_W-1:0]    cmd_len,
  output logic                done,
  output logic                err,
  output logic                rf_rd_en,
  output logic [ADDR_W-1:0]   rf_rd_addr,
  input  logic [N-1:0]        rf_rd_data,
  output logic                rf_wr_en,
  output logic [ADDR_W-1:0]   rf_wr_addr,
  output logic [N-1:0]        rf_wr_data,
  output logic [SDRAM_AW-1:0] sdram_address,
  output logic                sdram_read,
  output logic                sdram_write,
  output logic [SDRAM_DW-1:0] sdram_writedata,
  input  logic                sdram_waitrequest,
  input  logic [SDRAM_DW-1:0] sdram_readdata,
  input  logic                sdram_readdatavalid
);

  localparam int unsigned BEATS = N / SDRAM_DW;
  localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned CW    = LEN_W + BW;
  localparam int unsigned OW    = $clog2(MAX_OUTSTANDING) + 1;

  if ((N % SDRAM_DW) != 0 || N < SDRAM_DW) begin : g_bad_width
    $error("rf_sdram_dma: N must be a non-zero multiple of SDRAM_DW");
  end

  dma_state_t          state, state_nxt;
  logic [LEN_W-1:0]    len_q;
  logic [LEN_W-1:0]    row_cnt;
  logic [ADDR_W-1:0]   rf_ptr;
  logic [SDRAM_AW-1:0] sd_ptr;
  logic [CW-1:0]       issued, recv, total;
  logic [OW-1:0]       inflight;
  logic                wr_en_q, err_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [N-1:0]        wr_data_q;
  logic                accept, oob, rd_acc, wr_acc;
  logic [SDRAM_DW-1:0] tx_word;
  logic [N-1:0]        rx_row;
  logic                last_beat;

  assign accept = cmd_valid && cmd_ready;
  assign rd_acc = sdram_read && !sdram_waitrequest;
  assign wr_acc = sdram_write && !sdram_waitrequest;
  assign total  = CW'(len_q) * CW'(BEATS);

`ifdef RF_DMA_BOUNDS_CHECK_EN
  localparam int unsigned XW = SDRAM_AW + ADDR_W + LEN_W;
  // Ending exactly at the top of either space is legal; one past it is not.
  assign oob = (XW'(cmd_rf_addr) + XW'(cmd_len) > (XW'(1) << ADDR_W))
            || (XW'(cmd_sdram_addr) + XW'(cmd_len) * XW'(BEATS) > (XW'(1) << SDRAM_AW));
`else
  assign oob = 1'b0;
`endif

  dma_row_serdes #(.N(N), .DW(SDRAM_DW)) u_serdes (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (accept),
    .load      (state == S_CAP),
    .load_data (rf_rd_data),
    .shift_out (state == S_WR && !sdram_waitrequest),
    .shift_in  (state == L_RUN && sdram_readdatavalid),
    .beat_data (sdram_readdata),
    .tx_word   (tx_word),
    .rx_row    (rx_row),
    .last_beat (last_beat)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept && !oob) begin
          if (cmd_len == '0)             state_nxt = S_DONE;
          else if (cmd_dir == DMA_STORE) state_nxt = S_RD;
          else                           state_nxt = L_RUN;
        end
      end
      S_RD:  state_nxt = S_CAP;
      S_CAP: state_nxt = S_WR;
      S_WR: begin
        if (wr_acc && last_beat)
          state_nxt = (row_cnt == len_q - LEN_W'(1)) ? S_DONE : S_RD;
      end
      // The row write issued while every beat is already in is the final one.
      L_RUN:   if (wr_en_q && recv == total) state_nxt = S_DONE;
      S_DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Strobe decode; inputs of the read request never change while stalled.
  always_comb begin
    cmd_ready   = 1'b0;
    done        = 1'b0;
    rf_rd_en    = 1'b0;
    sdram_read  = 1'b0;
    sdram_write = 1'b0;
    case (state)
      IDLE:    cmd_ready   = 1'b1;
      S_RD:    rf_rd_en    = 1'b1;
      S_WR:    sdram_write = 1'b1;
      L_RUN:   sdram_read  = (issued < total) && (inflight < OW'(MAX_OUTSTANDING));
      S_DONE:  done        = 1'b1;
      default: ;
    endcase
  end

  assign rf_rd_addr      = rf_ptr;
  assign sdram_address   = sd_ptr;
  assign sdram_writedata = tx_word;
  assign rf_wr_en        = wr_en_q;
  assign rf_wr_addr      = wr_addr_q;
  assign rf_wr_data      = wr_data_q;
  assign err             = err_q;

  // Command pointers, load counters and the registered RF write port
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len_q     <= '0;
      row_cnt   <= '0;
      rf_ptr    <= '0;
      sd_ptr    <= '0;
      issued    <= '0;
      recv      <= '0;
      inflight  <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      err_q   <= accept && oob;
      if (accept) begin
        len_q    <= cmd_len;
        row_cnt  <= '0;
        rf_ptr   <= cmd_rf_addr;
        sd_ptr   <= cmd_sdram_addr;
        issued   <= '0;
        recv     <= '0;
        inflight <= '0;
      end
      if (state == S_WR && wr_acc) begin
        sd_ptr <= sd_ptr + SDRAM_AW'(1);
        if (last_beat) begin
          row_cnt <= row_cnt + LEN_W'(1);
          rf_ptr  <= rf_ptr + ADDR_W'(1);
        end
      end
      if (state == L_RUN) begin
        if (rd_acc) begin
          issued <= issued + CW'(1);
          sd_ptr <= sd_ptr + SDRAM_AW'(1);
        end
        inflight <= inflight + OW'(rd_acc) - OW'(sdram_readdatavalid);
        if (sdram_readdatavalid) begin
          recv <= recv + CW'(1);
          if (last_beat) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= rf_ptr;
            wr_data_q <= rx_row;
            rf_ptr    <= rf_ptr + ADDR_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_rf_sdram_dma.sv
// Directed bench for rf_sdram_dma (N=64, SDRAM_DW=16, MAX_OUTSTANDING=2).
`timescale 1ns/1ps
module tb_rf_sdram_dma;

  localparam int unsigned ADDR_W = 9;
  localparam int unsigned N      = 64;
  localparam int unsigned DW     = 16;
  localparam int unsigned LEN_W  = 9;
  localparam int unsigned MAXO   = 2;

  localparam logic [63:0] R5   = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] R6   = 64'hFEDC_BA98_7654_3210;
  localparam logic [63:0] R510 = 64'h1000_2000_3000_4000;
  localparam logic [63:0] R511 = 64'h5000_6000_7000_8000;
  localparam logic [63:0] R0   = 64'h9000_A000_B000_C000;
  localparam logic [63:0] R1   = 64'hD000_E000_F000_0ABC;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cmd_valid, cmd_ready, cmd_dir;
  logic [ADDR_W-1:0] cmd_rf_addr;
  logic [24:0]       cmd_sdram_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic              done, err;
  logic              rf_rd_en, rf_wr_en;
  logic [ADDR_W-1:0] rf_rd_addr, rf_wr_addr;
  logic [N-1:0]      rf_rd_data, rf_wr_data;
  logic [24:0]       sdram_address;
  logic              sdram_read, sdram_write, sdram_waitrequest, sdram_readdatavalid;
  logic [DW-1:0]     sdram_writedata, sdram_readdata;

  always #5 clk = ~clk;

  rf_sdram_dma #(.ADDR_W(ADDR_W), .N(N), .SDRAM_DW(DW), .LEN_W(LEN_W),
                 .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
    .cmd_rf_addr(cmd_rf_addr), .cmd_sdram_addr(cmd_sdram_addr), .cmd_len(cmd_len),
    .done(done), .err(err),
    .rf_rd_en(rf_rd_en), .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .sdram_address(sdram_address), .sdram_read(sdram_read), .sdram_write(sdram_write),
    .sdram_writedata(sdram_writedata), .sdram_waitrequest(sdram_waitrequest),
    .sdram_readdata(sdram_readdata), .sdram_readdatavalid(sdram_readdatavalid)
  );

  // Register-file read port model: data one cycle after the strobe.
  logic [N-1:0] rf_mem [0:511];
  always @(posedge clk) if (rf_rd_en) rf_rd_data <= rf_mem[rf_rd_addr];

  // SDRAM model: fixed read latency of 3, optional random waitrequest.
  logic [DW-1:0] sd_mem [0:4095];
  logic [2:0]    rv;
  logic [DW-1:0] rd0, rd1, rd2;
  logic          rand_wait;
  always @(posedge clk) begin
    if (!rst_n) begin
      rv                <= '0;
      sdram_waitrequest <= 1'b0;
    end else begin
      if (sdram_write && !sdram_waitrequest) sd_mem[sdram_address[11:0]] <= sdram_writedata;
      rv  <= {rv[1:0], sdram_read && !sdram_waitrequest};
      rd0 <= sd_mem[sdram_address[11:0]];
      rd1 <= rd0;
      rd2 <= rd1;
      sdram_waitrequest <= rand_wait ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end
  assign sdram_readdatavalid = rv[2];
  assign sdram_readdata      = rd2;

  // Bus monitor, sampled mid-cycle.
  int n_done = 0, n_err = 0, n_rfrd = 0, n_rfwr = 0, n_sdw = 0, n_sdr = 0;
  int n_unstable = 0, infl_m = 0, max_infl = 0;
  logic [ADDR_W-1:0] rfrd_addr [0:127];
  logic [ADDR_W-1:0] rfwr_addr [0:127];
  logic [N-1:0]      rfwr_data [0:127];
  logic [24:0]       sdw_addr  [0:127];
  logic [DW-1:0]     sdw_data  [0:127];
  logic              prev_stall = 1'b0, p_rd = 1'b0, p_wr = 1'b0;
  logic [24:0]       p_addr = '0;
  logic [DW-1:0]     p_wd = '0;

  always @(negedge clk) begin
    n_done = n_done + int'(done);
    n_err  = n_err + int'(err);
    if (rf_rd_en && n_rfrd < 128) begin rfrd_addr[n_rfrd] = rf_rd_addr; n_rfrd++; end
    if (rf_wr_en && n_rfwr < 128) begin
      rfwr_addr[n_rfwr] = rf_wr_addr; rfwr_data[n_rfwr] = rf_wr_data; n_rfwr++;
    end
    if (sdram_write && !sdram_waitrequest && n_sdw < 128) begin
      sdw_addr[n_sdw] = sdram_address; sdw_data[n_sdw] = sdram_writedata; n_sdw++;
    end
    if (!rst_n) begin
      infl_m     = 0;
      prev_stall = 1'b0;
    end else begin
      if (sdram_read && !sdram_waitrequest) n_sdr++;
      if (prev_stall && (sdram_read != p_rd || sdram_write != p_wr || sdram_address != p_addr
                         || (p_wr && sdram_writedata != p_wd)))
        n_unstable++;
      prev_stall = (sdram_read || sdram_write) && sdram_waitrequest;
      p_rd = sdram_read; p_wr = sdram_write; p_addr = sdram_address; p_wd = sdram_writedata;
      infl_m = infl_m + int'(sdram_read && !sdram_waitrequest) - int'(sdram_readdatavalid);
      if (infl_m > max_infl) max_infl = infl_m;
    end
  end

  int n_checks = 0, n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic issue(input logic dir, input logic [ADDR_W-1:0] ra,
                       input logic [24:0] sa, input logic [LEN_W-1:0] len);
    tick();
    cmd_dir = dir; cmd_rf_addr = ra; cmd_sdram_addr = sa; cmd_len = len;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int base, input string tag);
    bit seen = 1'b0;
    for (int k = 0; k < 300 && !seen; k++) begin
      tick();
      if (n_done != base) seen = 1'b1;
    end
    if (!seen) check({tag, "_timeout"}, 64'd0, 64'd1);
    repeat (5) tick();
  endtask

  logic [DW-1:0] t1_words [0:7];
  int b_done, b_err, b_rfrd, b_rfwr, b_sdw, b_sdr;

  task automatic snap();
    b_done = n_done; b_err = n_err; b_rfrd = n_rfrd;
    b_rfwr = n_rfwr; b_sdw = n_sdw; b_sdr = n_sdr;
  endtask

  initial begin
    t1_words = '{16'hCDEF, 16'h89AB, 16'h4567, 16'h0123,
                 16'h3210, 16'h7654, 16'hBA98, 16'hFEDC};
    rf_mem[5] = R5; rf_mem[6] = R6;
    rf_mem[510] = R510; rf_mem[511] = R511; rf_mem[0] = R0; rf_mem[1] = R1;
    cmd_valid = 1'b0; cmd_dir = 1'b0; cmd_rf_addr = '0; cmd_sdram_addr = '0; cmd_len = '0;
    rand_wait = 1'b0;
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Reset state
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst_strobes", 64'({done, err, rf_rd_en, rf_wr_en, sdram_read, sdram_write}), 64'd0);
    check("rst_addr", 64'(sdram_address), 64'd0);

    // 1: store rows 5,6 to 0x100
    snap();
    issue(1'b1, 9'd5, 25'h100, 9'd2);
    wait_done(b_done, "t1");
    check("t1_done_cnt", 64'(n_done - b_done), 64'd1);
    check("t1_rfrd_cnt", 64'(n_rfrd - b_rfrd), 64'd2);
    check("t1_rfrd0", 64'(rfrd_addr[b_rfrd]), 64'd5);
    check("t1_rfrd1", 64'(rfrd_addr[b_rfrd + 1]), 64'd6);
    check("t1_wr_cnt", 64'(n_sdw - b_sdw), 64'd8);
    for (int i = 0; i < 8; i++)
      check($sformatf("t1_beat%0d", i), 64'({sdw_addr[b_sdw + i], sdw_data[b_sdw + i]}),
            64'({25'h100 + 25'(i), t1_words[i]}));

    // 2: load 0x100 back into rows 20,21
    snap();
    issue(1'b0, 9'd20, 25'h100, 9'd2);
    wait_done(b_done, "t2");
    check("t2_done_cnt", 64'(n_done - b_done), 64'd1);
    check("t2_rd_beats", 64'(n_sdr - b_sdr), 64'd8);
    check("t2_rfwr_cnt", 64'(n_rfwr - b_rfwr), 64'd2);
    check("t2_row0_addr", 64'(rfwr_addr[b_rfwr]), 64'd20);
    check("t2_row0_data", rfwr_data[b_rfwr], R5);
    check("t2_row1_addr", 64'(rfwr_addr[b_rfwr + 1]), 64'd21);
    check("t2_row1_data", rfwr_data[b_rfwr + 1], R6);

    // 3: same load with random stalls
    snap();
    rand_wait = 1'b1;
    issue(1'b0, 9'd40, 25'h100, 9'd2);
    wait_done(b_done, "t3");
    rand_wait = 1'b0;
    check("t3_done_cnt", 64'(n_done - b_done), 64'd1);
    check("t3_row0", 64'({rfwr_addr[b_rfwr], 16'h0}), 64'({9'd40, 16'h0}));
    check("t3_row0_data", rfwr_data[b_rfwr], R5);
    check("t3_row1_data", rfwr_data[b_rfwr + 1], R6);
    check("t3_max_inflight_ok", 64'(max_infl <= 2), 64'd1);
    check("t3_stall_stable", 64'(n_unstable), 64'd0);

    // 4: zero length, then a command offered while busy
    snap();
    issue(1'b0, 9'd3, 25'h0, 9'd0);
    tick();
    check("t4_done_next", 64'(done), 64'd1);
    repeat (3) tick();
    check("t4_done_cnt", 64'(n_done - b_done), 64'd1);
    check("t4_no_bus", 64'((n_rfrd - b_rfrd) + (n_rfwr - b_rfwr) + (n_sdw - b_sdw) + (n_sdr - b_sdr)), 64'd0);
    snap();
    issue(1'b1, 9'd5, 25'h200, 9'd1);
    tick();
    cmd_dir = 1'b0; cmd_rf_addr = 9'd90; cmd_sdram_addr = 25'h100; cmd_len = 9'd1;
    cmd_valid = 1'b1;
    check("t4_busy_ready0", 64'(cmd_ready), 64'd0);
    tick();
    check("t4_busy_ready1", 64'(cmd_ready), 64'd0);
    cmd_valid = 1'b0;
    wait_done(b_done, "t4");
    check("t4_busy_done_cnt", 64'(n_done - b_done), 64'd1);
    check("t4_busy_beats", 64'(n_sdw - b_sdw), 64'd4);
    check("t4_busy_no_reads", 64'(n_sdr - b_sdr), 64'd0);

    // 5: store crossing the top of the RF
    snap();
    issue(1'b1, 9'd510, 25'h300, 9'd4);
`ifdef RF_DMA_BOUNDS_CHECK_EN
    tick();
    check("t5_err_pulse", 64'(err), 64'd1);
    repeat (10) tick();
    check("t5_err_cnt", 64'(n_err - b_err), 64'd1);
    check("t5_no_done", 64'(n_done - b_done), 64'd0);
    check("t5_no_bus", 64'((n_rfrd - b_rfrd) + (n_sdw - b_sdw)), 64'd0);
    check("t5_idle", 64'(cmd_ready), 64'd1);
`else
    wait_done(b_done, "t5");
    check("t5_done_cnt", 64'(n_done - b_done), 64'd1);
    check("t5_err_cnt", 64'(n_err - b_err), 64'd0);
    check("t5_rd0", 64'(rfrd_addr[b_rfrd]), 64'd510);
    check("t5_rd1", 64'(rfrd_addr[b_rfrd + 1]), 64'd511);
    check("t5_rd2", 64'(rfrd_addr[b_rfrd + 2]), 64'd0);
    check("t5_rd3", 64'(rfrd_addr[b_rfrd + 3]), 64'd1);
    check("t5_wr_cnt", 64'(n_sdw - b_sdw), 64'd16);
    check("t5_beat4", 64'({sdw_addr[b_sdw + 4], sdw_data[b_sdw + 4]}), 64'({25'h304, 16'h8000}));
    check("t5_beat8", 64'({sdw_addr[b_sdw + 8], sdw_data[b_sdw + 8]}), 64'({25'h308, 16'hC000}));
    check("t5_beat15", 64'({sdw_addr[b_sdw + 15], sdw_data[b_sdw + 15]}), 64'({25'h30F, 16'hD000}));
`endif

    // 6: reset in the middle of a load, then a clean load
    snap();
    issue(1'b0, 9'd60, 25'h100, 9'd2);
    for (int k = 0; k < 50 && (n_sdr - b_sdr) < 3; k++) tick();
    check("t6_third_beat", 64'((n_sdr - b_sdr) >= 3), 64'd1);
    rst_n = 1'b0;
    tick();
    check("t6_rst_strobes", 64'({done, err, rf_rd_en, rf_wr_en, sdram_read, sdram_write}), 64'd0);
    check("t6_rst_addr", 64'(sdram_address), 64'd0);
    check("t6_rst_wdata", rf_wr_data, 64'd0);
    check("t6_rst_ready", 64'(cmd_ready), 64'd1);
    rst_n = 1'b1;
    repeat (2) tick();
    check("t6_aborted_no_rfwr", 64'(n_rfwr - b_rfwr), 64'd0);
    check("t6_aborted_no_done", 64'(n_done - b_done), 64'd0);
    snap();
    issue(1'b0, 9'd70, 25'h104, 9'd1);
    wait_done(b_done, "t6");
    check("t6_done_cnt", 64'(n_done - b_done), 64'd1);
    check("t6_rfwr_cnt", 64'(n_rfwr - b_rfwr), 64'd1);
    check("t6_row_addr", 64'(rfwr_addr[b_rfwr]), 64'd70);
    check("t6_row_data", rfwr_data[b_rfwr], R6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
